// File: rtl/dram_arb_pkg.sv
// Shared types for the 2:1 DRAM AXI4 arbiter: bus widths, FSM state
// encodings, requester index type and the default requester-tag ID bit.
package dram_arb_pkg;

    localparam int ID_SEL_BIT_DEF = 15;
    localparam int ID_W           = 16;
    localparam int ADDR_W         = 64;
    localparam int DATA_W         = 512;
    localparam int STRB_W         = DATA_W / 8;

    // Requester index: 0 = host DMA, 1 = traffic generator
    typedef logic req_idx_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_ADDR
    } rd_state_e;

endpackage

// File: rtl/dram_axi_arb2_if.sv
// AXI4 bus bundle (512b data, 64b addr, 16b id) used on all arbiter ports.
// master: drives AW/W/AR and B/R ready. slave: drives the opposite set.
interface dram_axi_arb2_if;
    import dram_arb_pkg::*;

    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;

    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/dram_arb_rr2.sv
// 2-way round-robin picker. req_i: requests, pref_i: side that wins a tie.
// gnt_o: selected requester, any_o: at least one request present.
module dram_arb_rr2
    import dram_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  req_idx_t   pref_i,
    output req_idx_t   gnt_o,
    output logic       any_o
);

    assign any_o = |req_i;
    assign gnt_o = (&req_i) ? pref_i : req_i[1];

endmodule

// File: rtl/dram_axi_arb2.sv
// 2:1 AXI4 arbiter in front of mock_dram. Ports: clk, rst_n, s0/s1 (requesters),
// m (to DRAM), wr_outst0/1 and rd_outst0/1 (outstanding bursts per requester).
module dram_axi_arb2
    import dram_arb_pkg::*;
#(
    parameter int ID_SEL_BIT = ID_SEL_BIT_DEF,
    parameter int MAX_OUTST  = 16,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    dram_axi_arb2_if.slave   s0,
    dram_axi_arb2_if.slave   s1,
    dram_axi_arb2_if.master  m,
    output logic [CNT_W-1:0] wr_outst0,
    output logic [CNT_W-1:0] wr_outst1,
    output logic [CNT_W-1:0] rd_outst0,
    output logic [CNT_W-1:0] rd_outst1
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTST);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    wr_state_e        w_st_q;
    rd_state_e        r_st_q;
    req_idx_t         wg_q, rg_q, w_ptr_q, r_ptr_q;
    logic [CNT_W-1:0] wr_cnt_q [2];
    logic [CNT_W-1:0] rd_cnt_q [2];

    logic [1:0] w_elig, r_elig;
    req_idx_t   w_gnt, r_gnt, b_tag, r_tag;
    logic       w_any, r_any;
    logic       aw_hs, wl_hs, ar_hs, b_hs, rl_hs;
    logic [1:0] wr_inc, wr_dec, rd_inc, rd_dec;

    assign w_elig = {s1.awvalid && (wr_cnt_q[1] < MAX_C),
                     s0.awvalid && (wr_cnt_q[0] < MAX_C)};
    assign r_elig = {s1.arvalid && (rd_cnt_q[1] < MAX_C),
                     s0.arvalid && (rd_cnt_q[0] < MAX_C)};

    dram_arb_rr2 u_rr_w (
        .req_i  (w_elig),
        .pref_i (w_ptr_q),
        .gnt_o  (w_gnt),
        .any_o  (w_any)
    );

    dram_arb_rr2 u_rr_r (
        .req_i  (r_elig),
        .pref_i (r_ptr_q),
        .gnt_o  (r_gnt),
        .any_o  (r_any)
    );

    assign aw_hs = (w_st_q == W_ADDR) && m.awvalid && m.awready;
    assign wl_hs = (w_st_q == W_DATA) && m.wvalid && m.wready && m.wlast;
    assign ar_hs = (r_st_q == R_ADDR) && m.arvalid && m.arready;
    assign b_tag = m.bid[ID_SEL_BIT];
    assign r_tag = m.rid[ID_SEL_BIT];
    assign b_hs  = m.bvalid && m.bready;
    assign rl_hs = m.rvalid && m.rready && m.rlast;

    assign wr_inc = {aw_hs && wg_q, aw_hs && !wg_q};
    assign wr_dec = {b_hs && b_tag, b_hs && !b_tag};
    assign rd_inc = {ar_hs && rg_q, ar_hs && !rg_q};
    assign rd_dec = {rl_hs && r_tag, rl_hs && !r_tag};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_st_q  <= W_IDLE;
            wg_q    <= 1'b0;
            w_ptr_q <= 1'b0;
        end else begin
            unique case (w_st_q)
                W_IDLE: if (w_any) begin
                    wg_q   <= w_gnt;
                    w_st_q <= W_ADDR;
                end
                W_ADDR: if (aw_hs) w_st_q <= W_DATA;
                W_DATA: if (wl_hs) begin
                    w_ptr_q <= ~wg_q;
                    w_st_q  <= W_IDLE;
                end
                default: w_st_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st_q  <= R_IDLE;
            rg_q    <= 1'b0;
            r_ptr_q <= 1'b0;
        end else begin
            unique case (r_st_q)
                R_IDLE: if (r_any) begin
                    rg_q   <= r_gnt;
                    r_st_q <= R_ADDR;
                end
                R_ADDR: if (ar_hs) begin
                    r_ptr_q <= ~rg_q;
                    r_st_q  <= R_IDLE;
                end
                default: r_st_q <= R_IDLE;
            endcase
        end
    end

    // Simultaneous inc/dec leaves a counter unchanged; never wraps below 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                wr_cnt_q[k] <= '0;
                rd_cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (wr_inc[k] && !wr_dec[k])
                    wr_cnt_q[k] <= wr_cnt_q[k] + ONE_C;
                else if (wr_dec[k] && !wr_inc[k] && wr_cnt_q[k] != '0)
                    wr_cnt_q[k] <= wr_cnt_q[k] - ONE_C;
                if (rd_inc[k] && !rd_dec[k])
                    rd_cnt_q[k] <= rd_cnt_q[k] + ONE_C;
                else if (rd_dec[k] && !rd_inc[k] && rd_cnt_q[k] != '0)
                    rd_cnt_q[k] <= rd_cnt_q[k] - ONE_C;
            end
        end
    end

    assign wr_outst0 = wr_cnt_q[0];
    assign wr_outst1 = wr_cnt_q[1];
    assign rd_outst0 = rd_cnt_q[0];
    assign rd_outst1 = rd_cnt_q[1];

    // AW forwarded only after the grant is registered
    always_comb begin
        m.awid     = '0;
        m.awaddr   = '0;
        m.awlen    = '0;
        m.awsize   = '0;
        m.awburst  = '0;
        m.awvalid  = 1'b0;
        s0.awready = 1'b0;
        s1.awready = 1'b0;
        if (w_st_q == W_ADDR) begin
            m.awid     = wg_q ? s1.awid    : s0.awid;
            m.awaddr   = wg_q ? s1.awaddr  : s0.awaddr;
            m.awlen    = wg_q ? s1.awlen   : s0.awlen;
            m.awsize   = wg_q ? s1.awsize  : s0.awsize;
            m.awburst  = wg_q ? s1.awburst : s0.awburst;
            m.awvalid  = wg_q ? s1.awvalid : s0.awvalid;
            m.awid[ID_SEL_BIT] = wg_q;
            s0.awready = m.awready && !wg_q;
            s1.awready = m.awready && wg_q;
        end
    end

    // W is never forwarded before its AW has been accepted
    always_comb begin
        m.wdata   = '0;
        m.wstrb   = '0;
        m.wlast   = 1'b0;
        m.wvalid  = 1'b0;
        s0.wready = 1'b0;
        s1.wready = 1'b0;
        if (w_st_q == W_DATA) begin
            m.wdata   = wg_q ? s1.wdata  : s0.wdata;
            m.wstrb   = wg_q ? s1.wstrb  : s0.wstrb;
            m.wlast   = wg_q ? s1.wlast  : s0.wlast;
            m.wvalid  = wg_q ? s1.wvalid : s0.wvalid;
            s0.wready = m.wready && !wg_q;
            s1.wready = m.wready && wg_q;
        end
    end

    always_comb begin
        m.arid     = '0;
        m.araddr   = '0;
        m.arlen    = '0;
        m.arsize   = '0;
        m.arburst  = '0;
        m.arvalid  = 1'b0;
        s0.arready = 1'b0;
        s1.arready = 1'b0;
        if (r_st_q == R_ADDR) begin
            m.arid     = rg_q ? s1.arid    : s0.arid;
            m.araddr   = rg_q ? s1.araddr  : s0.araddr;
            m.arlen    = rg_q ? s1.arlen   : s0.arlen;
            m.arsize   = rg_q ? s1.arsize  : s0.arsize;
            m.arburst  = rg_q ? s1.arburst : s0.arburst;
            m.arvalid  = rg_q ? s1.arvalid : s0.arvalid;
            m.arid[ID_SEL_BIT] = rg_q;
            s0.arready = m.arready && !rg_q;
            s1.arready = m.arready && rg_q;
        end
    end

    // Responses steered by the tag bit, which is stripped on the way back
    always_comb begin
        s0.bid    = m.bid;
        s1.bid    = m.bid;
        s0.bid[ID_SEL_BIT] = 1'b0;
        s1.bid[ID_SEL_BIT] = 1'b0;
        s0.bresp  = m.bresp;
        s1.bresp  = m.bresp;
        s0.bvalid = m.bvalid && !b_tag;
        s1.bvalid = m.bvalid && b_tag;
        m.bready  = b_tag ? s1.bready : s0.bready;
    end

    always_comb begin
        s0.rid    = m.rid;
        s1.rid    = m.rid;
        s0.rid[ID_SEL_BIT] = 1'b0;
        s1.rid[ID_SEL_BIT] = 1'b0;
        s0.rdata  = m.rdata;
        s1.rdata  = m.rdata;
        s0.rresp  = m.rresp;
        s1.rresp  = m.rresp;
        s0.rlast  = m.rlast;
        s1.rlast  = m.rlast;
        s0.rvalid = m.rvalid && !r_tag;
        s1.rvalid = m.rvalid && r_tag;
        m.rready  = r_tag ? s1.rready : s0.rready;
    end

    logic tag_err;
    logic [1:0] uflow;

    assign tag_err = (s0.awvalid && s0.awid[ID_SEL_BIT]) ||
                     (s1.awvalid && s1.awid[ID_SEL_BIT]) ||
                     (s0.arvalid && s0.arid[ID_SEL_BIT]) ||
                     (s1.arvalid && s1.arid[ID_SEL_BIT]);

    assign uflow[0] = |(wr_dec & ~wr_inc &
                        {wr_cnt_q[1] == '0, wr_cnt_q[0] == '0});
    assign uflow[1] = |(rd_dec & ~rd_inc &
                        {rd_cnt_q[1] == '0, rd_cnt_q[0] == '0});

    a_tag: assert property (@(posedge clk) disable iff (!rst_n) !tag_err);
    a_uflow: assert property (@(posedge clk) disable iff (!rst_n) uflow == 2'b00);

endmodule
